shiftreg_ctrl: RTL and testbench



---
 rtl/shiftreg_pkg.sv | 14 +
 rtl/shiftreg_ctrl.sv | 144 ++++++++++++++
 tb/tb_shiftreg_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/shiftreg_pkg.sv
// Shared types and constants for the delay-line flow controller.
package shiftreg_pkg;

  localparam int unsigned DefaultDepth = 20000;
  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned StatsWidth   = 16;

  typedef enum logic [1:0] {
    StFill,
    StStream,
    StFlush
  } state_e;

endpackage

// File: rtl/shiftreg_ctrl.sv
// Valid/ready flow controller for an external lockstep delay line.
// Optional stall counter output when SHIFTREG_CTRL_STATS_EN is defined.
module shiftreg_ctrl
  import shiftreg_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned W     = DefaultWidth,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  input  logic          flush_req,
  output logic          flush_busy,
  output logic [CW-1:0] valid_cnt,
  output logic          line_shift_en,
  output logic [W-1:0]  line_data_in,
  input  logic [W-1:0]  line_data_out
`ifdef SHIFTREG_CTRL_STATS_EN
  ,
  output logic [StatsWidth-1:0] stall_cnt
`endif
);

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] One    = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] head_gap_q, head_gap_d;
  logic [CW-1:0] valid_q, valid_d;
  logic [CW-1:0] tail_gap_q, tail_gap_d;
  logic          shift;
  logic          flush_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFill;
      head_gap_q <= DepthC;
      valid_q    <= '0;
      tail_gap_q <= '0;
    end else begin
      state_q    <= state_d;
      head_gap_q <= head_gap_d;
      valid_q    <= valid_d;
      tail_gap_q <= tail_gap_d;
    end
  end

  // Last valid byte leaves the line on this edge.
  assign flush_done = (state_q == StFlush) && shift && (head_gap_q == '0) && (valid_q == One);

  always_comb begin
    state_d    = state_q;
    head_gap_d = head_gap_q;
    valid_d    = valid_q;
    tail_gap_d = tail_gap_q;
    case (state_q)
      StFill: begin
        if (shift) begin
          head_gap_d = head_gap_q - One;
          valid_d    = valid_q + One;
          if (head_gap_q == One) state_d = StStream;
        end
        if (flush_req && (valid_d != '0)) state_d = StFlush;
      end
      StStream: begin
        if (flush_req && (valid_q != '0)) state_d = StFlush;
      end
      StFlush: begin
        if (shift) begin
          tail_gap_d = tail_gap_q + One;
          if (head_gap_q != '0) begin
            head_gap_d = head_gap_q - One;
          end else begin
            valid_d = valid_q - One;
          end
        end
        if (flush_done) begin
          state_d    = StFill;
          head_gap_d = DepthC;
          tail_gap_d = '0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    shift        = 1'b0;
    line_data_in = '0;
    case (state_q)
      StFill: begin
        in_ready     = 1'b1;
        line_data_in = in_data;
        shift        = in_valid;
      end
      StStream: begin
        in_ready     = out_ready;
        out_valid    = in_valid;
        line_data_in = in_data;
        shift        = in_valid && out_ready;
      end
      StFlush: begin
        // Bubbles at the head are pushed out without involving the consumer.
        if (head_gap_q != '0) begin
          shift = 1'b1;
        end else begin
          out_valid = 1'b1;
          shift     = out_ready;
        end
      end
      default: ;
    endcase
  end

  assign out_data      = line_data_out;
  assign line_shift_en = shift;
  assign flush_busy    = (state_q == StFlush);
  assign valid_cnt     = valid_q;

`ifdef SHIFTREG_CTRL_STATS_EN
  logic [StatsWidth-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (flush_done) begin
      stall_q <= '0;
    end else if (in_valid && !in_ready && (stall_q != '1)) begin
      stall_q <= stall_q + StatsWidth'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// Directed self-checking bench for shiftreg_ctrl with a 4-stage behavioural delay line.
module tb_shiftreg_ctrl;
  import shiftreg_pkg::*;

  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, flush_req, flush_busy;
  logic [7:0] in_data, out_data, line_data_in, line_data_out;
  logic [2:0] valid_cnt;
  logic       line_shift_en;
`ifdef SHIFTREG_CTRL_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shiftreg_ctrl #(
    .DEPTH(Depth),
    .W    (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .flush_req    (flush_req),
    .flush_busy   (flush_busy),
    .valid_cnt    (valid_cnt),
    .line_shift_en(line_shift_en),
    .line_data_in (line_data_in),
    .line_data_out(line_data_out)
`ifdef SHIFTREG_CTRL_STATS_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  // Behavioural delay line, deliberately not reset; starts with stale bytes.
  logic [7:0] line_q [Depth];
  initial for (int i = 0; i < Depth; i++) line_q[i] = 8'hEE;
  always @(posedge clk) begin
    if (line_shift_en) begin
      line_q[0] <= line_data_in;
      for (int i = 1; i < Depth; i++) line_q[i] <= line_q[i-1];
    end
  end
  assign line_data_out = line_q[Depth-1];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_io(input string tag, input logic rdy, input logic vld, input logic sh);
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(vld));
    check_eq({tag, ".shift"}, 32'(line_shift_en), 32'(sh));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    #3;
    expect_io("fill_push", 1'b1, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  logic [7:0] fill_v [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] drain_v [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
  logic       part_ov [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] part_d [4]  = '{8'h00, 8'h00, 8'hA1, 8'hA2};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush_req = 1'b0;
    #12;
    expect_io("reset", 1'b1, 1'b0, 1'b0);
    check_eq("reset.flush_busy", 32'(flush_busy), 32'd0);
    check_eq("reset.valid_cnt", 32'(valid_cnt), 32'd0);
    tick();
    rst_n = 1'b1;

    // Fill: four bytes, nothing leaves.
    for (int i = 0; i < 4; i++) push(fill_v[i]);
    #3;
    check_eq("fill.valid_cnt", 32'(valid_cnt), 32'd4);
    check_eq("fill.state", 32'(dut.state_q), 32'(StStream));
    check_eq("fill.out_valid", 32'(out_valid), 32'd0);
    check_eq("fill.head", 32'(out_data), 32'h11);
    tick();

    // Backpressure in STREAM.
    in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      expect_io("bp", 1'b0, 1'b1, 1'b0);
      check_eq("bp.out_data", 32'(out_data), 32'h11);
      tick();
    end
`ifdef SHIFTREG_CTRL_STATS_EN
    #3;
    check_eq("stats.stall3", 32'(stall_cnt), 32'd3);
    tick();
    #3;
    check_eq("stats.stall4", 32'(stall_cnt), 32'd4);
`endif
    out_ready = 1'b1;
    #3;
    expect_io("stream", 1'b1, 1'b1, 1'b1);
    check_eq("stream.out_data", 32'(out_data), 32'h11);
    tick();
    in_valid = 1'b0;
    #3;
    check_eq("stream.next", 32'(out_data), 32'h22);
    check_eq("stream.valid_cnt", 32'(valid_cnt), 32'd4);

    // Full flush from STREAM.
    flush_req = 1'b1;
    check_eq("flush_full.req_busy", 32'(flush_busy), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #3;
      check_eq("flush_full.busy", 32'(flush_busy), 32'd1);
      expect_io("flush_full", 1'b0, 1'b1, 1'b1);
      check_eq("flush_full.data", 32'(out_data), 32'(drain_v[i]));
      tick();
    end
    #3;
    check_eq("flush_full.done_busy", 32'(flush_busy), 32'd0);
    check_eq("flush_full.valid_cnt", 32'(valid_cnt), 32'd0);
    check_eq("flush_full.state", 32'(dut.state_q), 32'(StFill));
`ifdef SHIFTREG_CTRL_STATS_EN
    check_eq("stats.cleared", 32'(stall_cnt), 32'd0);
`endif
    tick();
    #3;
    check_eq("flush_empty.ignored", 32'(flush_busy), 32'd0);
    tick();
    flush_req = 1'b0;

    // Partial flush: two bubbles then two bytes.
    push(8'hA1);
    push(8'hA2);
    flush_req = 1'b1;
    #3;
    check_eq("flush_part.valid_cnt", 32'(valid_cnt), 32'd2);
    check_eq("flush_part.req_busy", 32'(flush_busy), 32'd0);
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #3;
      check_eq("flush_part.busy", 32'(flush_busy), 32'd1);
      expect_io("flush_part", 1'b0, part_ov[i], 1'b1);
      if (part_ov[i]) check_eq("flush_part.data", 32'(out_data), 32'(part_d[i]));
      tick();
    end
    #3;
    check_eq("flush_part.done_busy", 32'(flush_busy), 32'd0);
    check_eq("flush_part.valid_cnt", 32'(valid_cnt), 32'd0);

    // Push and flush request in the same cycle.
    in_valid = 1'b1; in_data = 8'hB1; flush_req = 1'b1;
    #3;
    expect_io("push_flush", 1'b1, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0; flush_req = 1'b0;
    #3;
    check_eq("push_flush.valid_cnt", 32'(valid_cnt), 32'd1);
    check_eq("push_flush.busy", 32'(flush_busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      #3;
      expect_io("push_flush.bubble", 1'b0, 1'b0, 1'b1);
      tick();
    end
    #3;
    expect_io("push_flush.out", 1'b0, 1'b1, 1'b1);
    check_eq("push_flush.data", 32'(out_data), 32'hB1);
    tick();
    #3;
    check_eq("push_flush.done_busy", 32'(flush_busy), 32'd0);

    // Reset in the middle of a flush.
    push(8'hC1);
    push(8'hC2);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    #3;
    check_eq("rst_flush.busy", 32'(flush_busy), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("rst_flush.state", 32'(dut.state_q), 32'(StFill));
    check_eq("rst_flush.busy0", 32'(flush_busy), 32'd0);
    check_eq("rst_flush.valid_cnt", 32'(valid_cnt), 32'd0);
    expect_io("rst_flush", 1'b1, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;

    // Stale line contents must never surface while refilling.
    for (int i = 0; i < 4; i++) push(8'hD1 + 8'(i));
    #3;
    check_eq("refill.state", 32'(dut.state_q), 32'(StStream));
    in_valid = 1'b1; in_data = 8'hE5;
    #1;
    expect_io("refill.stream", 1'b1, 1'b1, 1'b1);
    check_eq("refill.head", 32'(out_data), 32'hD1);

    // Reset in the middle of streaming.
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    expect_io("rst_stream", 1'b1, 1'b0, 1'b0);
    check_eq("rst_stream.busy", 32'(flush_busy), 32'd0);
    check_eq("rst_stream.valid_cnt", 32'(valid_cnt), 32'd0);
    tick();
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
